iht_engine: RTL and testbench
=============================

Name: iht_engine

Overview:
- Inverse fast Walsh-Hadamard transform engine; undoes the forward transform stage chain.
- Takes INDEX signed coefficients and runs LOG2N butterfly stages iteratively, one stage per clock, over a register array.
- Scales the result by 1/INDEX and returns INDEX unsigned WIDTH-bit samples.
- Sits after the forward transform in the round-trip datapath; start/done handshake.

Parameters:
- INDEX, 32, number of elements; power of two, ≥2.
- WIDTH, 5, output sample width (unsigned).
- LOG2N, 5, number of stages; must equal log2(INDEX).
- CW, 11, input coefficient width (signed two's complement); CW = WIDTH+LOG2N+1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- coef  in  CW x [0:INDEX-1]  signed coefficients; captured on the accepted start edge.
- busy  out  1  high from the accepted start edge until done is asserted.
- outdata  out  WIDTH x [0:INDEX-1]  recovered samples; held until the next completion.
- done  out  1  one-cycle pulse when outdata is updated.
- inexact  out  1  valid with done; held with outdata.

Behaviour:
- Internal width: IW = CW+LOG2N, signed. All butterfly arithmetic is at IW; there is no overflow for legal inputs.
- Registers: work[0:INDEX-1] at IW, stage counter s of LOG2N bits, and state.
- States and transitions:
  - IDLE: start=1 → work[i] = sign-extended coef[i], s=0, busy=1 → RUN.
  - RUN: each cycle performs stage s. Distance d = 2^s. For every i with bit s of i = 0: a=work[i], b=work[i+d]; work[i] ← a+b; work[i+d] ← a−b. All pairs update in parallel.
    - s = LOG2N−1 → SCALE.
    - Otherwise s ← s+1.
  - SCALE: q[i] = work[i] >>> LOG2N (arithmetic shift, floor division). outdata[i] ← q[i][WIDTH-1:0]. inexact ← 1 if any element has nonzero low LOG2N bits, or any q[i] lies outside [0, 2^WIDTH−1]. done ← 1, busy ← 0 → IDLE.
- Latency: start sampled at edge k; the stages execute at edges k+1..k+LOG2N; outputs, done and inexact update at edge k+LOG2N+1. For the defaults that is 6 edges: done is high in the 6th cycle after the start cycle.
- Throughput: one transform per LOG2N+2 cycles. A start held high through the done cycle is accepted in the IDLE cycle immediately after.
- start while busy: ignored, not queued.
- coef changes after the capture edge have no effect.
- done is high for exactly one cycle. outdata and inexact are stable between done pulses.
- Reset, at any time including mid-RUN or SCALE:
  - state IDLE, s=0, work all 0.
  - outdata all 0, done=0, busy=0, inexact=0.
  - The in-flight transform is discarded; no done is produced for it.
- Stage order is natural (Sylvester) order, d = 1,2,4,…, identical to the forward transform. The inverse is therefore H·y/INDEX.

Test Plan:
- Reset: coef[0]=32, others 0, start=1 → done 6 cycles later. outdata all 1, inexact=0. busy high for exactly 6 cycles, starting the cycle after the start edge.
- Constant: coef[0]=992, others 0 → outdata all 31, inexact=0. Then coef[1]=−32, rest as before → outdata[even]=30, outdata[odd]=32 wraps to 0, inexact=1.
- Round trip: x[i]=i for i=0..31; coef = forward WHT of x computed by the bench model (coef[0]=496, coef[1]=−16, coef[2]=−32, …) → outdata[i]=i, inexact=0. Repeat with 200 random x vectors → exact match each time.
- Non-divisible input: coef[0]=1, others 0 → outdata all 0, inexact=1. Next transform with exact input clears inexact to 0.
- Handshake:
  - start held high continuously → done pulses every 7 cycles.
  - start pulse during RUN with different coef → ignored; outdata reflects the first capture only.
  - coef changed during RUN → result unchanged.
- Reset mid-op: assert rst at cycle 3 of RUN → no done. outdata=0, busy=0 the cycle after. A new start afterwards completes normally with correct data.

Source files
------------

// File: rtl/iht_engine.sv
`default_nettype none
// ============================================================================
//  Module      : iht_engine
//  Description : Inverse fast Walsh-Hadamard transform engine. Captures INDEX
//                signed coefficients, runs LOG2N in-place butterfly stages
//                (one per clock, natural/Sylvester order d = 1,2,4,...),
//                then divides by INDEX with an arithmetic shift and returns
//                INDEX unsigned WIDTH-bit samples.
//
//  Ports       : clk      - clock, rising edge
//                rst      - synchronous active-high reset
//                start    - transform request, sampled only while idle
//                coef     - INDEX x CW signed coefficients, captured on the
//                           accepted start edge
//                busy     - high from the accepted start edge until done
//                outdata  - INDEX x WIDTH recovered samples, held between
//                           completions
//                done     - one-cycle pulse when outdata/inexact update
//                inexact  - result was not an exact in-range integer sample
//
//  Revision    : 1.0 - initial release
// ============================================================================
module iht_engine #(
    parameter int INDEX = 32,
    parameter int WIDTH = 5,
    parameter int LOG2N = 5,
    parameter int CW    = 11
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [0:INDEX-1][CW-1:0]      coef,
    output logic                          busy,
    output logic [0:INDEX-1][WIDTH-1:0]   outdata,
    output logic                          done,
    output logic                          inexact
);

    // Internal width: worst-case growth of LOG2N add/sub stages.
    localparam int IW = CW + LOG2N;

    localparam logic [1:0]       c_idle  = 2'd0;
    localparam logic [1:0]       c_run   = 2'd1;
    localparam logic [1:0]       c_scale = 2'd2;
    localparam logic [LOG2N-1:0] c_last  = LOG2N'(LOG2N - 1);
    localparam logic [LOG2N-1:0] c_one   = LOG2N'(1);

    logic [1:0]                 r_state;
    logic [1:0]                 w_state_nxt;
    logic [LOG2N-1:0]           r_s;
    logic [LOG2N-1:0]           w_mask;

    logic signed [IW-1:0]       r_work  [0:INDEX-1];
    logic signed [IW-1:0]       w_stage [0:INDEX-1];
    logic signed [IW-1:0]       w_q     [0:INDEX-1];
    logic [INDEX-1:0]           w_flag;

    logic [0:INDEX-1][WIDTH-1:0] r_outdata;
    logic                       r_done;
    logic                       r_inexact;

    logic                       w_capture;
    logic                       w_step;
    logic                       w_finish;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (start) w_state_nxt = c_run;
            c_run:   if (r_s == c_last) w_state_nxt = c_scale;
            c_scale: w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    always_comb begin
        busy      = 1'b0;
        w_capture = 1'b0;
        w_step    = 1'b0;
        w_finish  = 1'b0;
        case (r_state)
            c_idle:  w_capture = start;
            c_run:   begin busy = 1'b1; w_step   = 1'b1; end
            c_scale: begin busy = 1'b1; w_finish = 1'b1; end
            default: ;
        endcase
    end

    // Pair distance for the current stage, d = 2^s, as a bit mask.
    assign w_mask = c_one << r_s;

    // ------------------------------------------------------------------
    // Butterfly network for stage s. Each element finds its partner by
    // flipping bit s of its index; the lower element of the pair takes
    // a+b, the upper takes a-b, so every element is written exactly once.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < INDEX; i++) begin : g_bfly
        logic [LOG2N-1:0] w_idx;
        logic [LOG2N-1:0] w_pidx;
        logic             w_upper;

        assign w_idx   = LOG2N'(i);
        assign w_pidx  = w_idx ^ w_mask;
        assign w_upper = |(w_idx & w_mask);
        assign w_stage[i] = w_upper ? (r_work[w_pidx] - r_work[i])
                                    : (r_work[i] + r_work[w_pidx]);
    end

    // ------------------------------------------------------------------
    // Scaling by 1/INDEX. The arithmetic shift floors; a result is inexact
    // when discarded fraction bits are nonzero or the quotient does not fit
    // the unsigned output range (any bit at or above WIDTH set, which also
    // catches negative quotients through the sign bit).
    // ------------------------------------------------------------------
    for (genvar i = 0; i < INDEX; i++) begin : g_scale
        assign w_q[i]    = r_work[i] >>> LOG2N;
        assign w_flag[i] = (|r_work[i][LOG2N-1:0]) | (|w_q[i][IW-1:WIDTH]);
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s       <= '0;
            r_outdata <= '0;
            r_done    <= 1'b0;
            r_inexact <= 1'b0;
            for (int i = 0; i < INDEX; i++) begin
                r_work[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            if (w_capture) begin
                r_s <= '0;
                for (int i = 0; i < INDEX; i++) begin
                    r_work[i] <= IW'($signed(coef[i]));
                end
            end else if (w_step) begin
                r_s <= (r_s == c_last) ? '0 : r_s + c_one;
                for (int i = 0; i < INDEX; i++) begin
                    r_work[i] <= w_stage[i];
                end
            end else if (w_finish) begin
                for (int i = 0; i < INDEX; i++) begin
                    r_outdata[i] <= w_q[i][WIDTH-1:0];
                end
                r_inexact <= |w_flag;
                r_done    <= 1'b1;
            end
        end
    end

    assign outdata = r_outdata;
    assign done    = r_done;
    assign inexact = r_inexact;

endmodule
`default_nettype wire

// File: tb/tb_iht_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iht_engine
//  Description : Self-checking bench for iht_engine. Stimulus pushes expected
//                results into a scoreboard queue; a monitor pops and compares
//                on every done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iht_engine;

    localparam int N  = 32;
    localparam int W  = 5;
    localparam int L  = 5;
    localparam int CW = 11;

    typedef logic [0:N-1][CW-1:0] coef_t;
    typedef logic [0:N-1][W-1:0]  out_t;
    typedef struct {
        out_t o;
        logic inx;
    } exp_t;

    logic  clk;
    logic  rst;
    logic  start;
    coef_t coef;
    logic  busy;
    out_t  outdata;
    logic  done;
    logic  inexact;

    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;
    exp_t  sb[$];

    iht_engine #(.INDEX(N), .WIDTH(W), .LOG2N(L), .CW(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .coef    (coef),
        .busy    (busy),
        .outdata (outdata),
        .done    (done),
        .inexact (inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, want no done", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checks = checks + 1;
                if (outdata !== e.o) begin
                    errors = errors + 1;
                    $display("FAIL outdata: got %h want %h", outdata, e.o);
                end
                checks = checks + 1;
                if (inexact !== e.inx) begin
                    errors = errors + 1;
                    $display("FAIL inexact: got %b want %b", inexact, e.inx);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    function automatic coef_t fwd(input out_t x);
        int    v [N];
        int    a;
        int    b;
        coef_t c;
        for (int i = 0; i < N; i++) v[i] = int'(x[i]);
        for (int d = 1; d < N; d = d * 2) begin
            for (int i = 0; i < N; i++) begin
                if ((i & d) == 0) begin
                    a = v[i];
                    b = v[i+d];
                    v[i]   = a + b;
                    v[i+d] = a - b;
                end
            end
        end
        for (int i = 0; i < N; i++) c[i] = CW'(v[i]);
        return c;
    endfunction

    function automatic out_t fill(input int val);
        out_t o;
        for (int i = 0; i < N; i++) o[i] = W'(val);
        return o;
    endfunction

    task automatic check(input string name, input int got, input int want);
        checks = checks + 1;
        if (got != want) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic expect_res(input out_t o, input logic inx);
        exp_t e;
        e.o   = o;
        e.inx = inx;
        sb.push_back(e);
    endtask

    // Drive a one-cycle start; returns at #1 after the accepting edge.
    task automatic launch(input coef_t c);
        @(negedge clk);
        coef  = c;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges until done and how many samples had busy high
    // (including the sample right after the accepting edge).
    task automatic wait_done(output int n, output int nb);
        n  = 0;
        nb = (busy === 1'b1) ? 1 : 0;
        do begin
            @(posedge clk);
            #1;
            n = n + 1;
            if (busy === 1'b1 && done !== 1'b1) nb = nb + 1;
        end while (done !== 1'b1 && n < 40);
        if (done !== 1'b1) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL done_timeout: got no done within %0d cycles, want done", n);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        coef_t c;
        out_t  x;
        out_t  xb;
        int    n;
        int    nb;
        int    t [3];
        int    ndone;

        rst   = 1'b1;
        start = 1'b0;
        coef  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outdata", int'(outdata == '0), 1);
        check("reset_done", int'(done), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_inexact", int'(inexact), 0);
        rst = 1'b0;

        // DC of 32 -> all ones, latency and busy window
        c = '0; c[0] = CW'(32);
        expect_res(fill(1), 1'b0);
        launch(c);
        check("busy_after_start", int'(busy), 1);
        wait_done(n, nb);
        check("latency", n, 6);
        check("busy_cycles", nb, 6);
        check("busy_at_done", int'(busy), 0);
        @(posedge clk); #1;
        check("done_one_cycle", int'(done), 0);

        // Max constant, then odd component producing wrap
        c = '0; c[0] = CW'(992);
        expect_res(fill(31), 1'b0);
        launch(c); wait_done(n, nb);
        c[1] = CW'(-32);
        for (int i = 0; i < N; i++) x[i] = (i % 2 == 0) ? W'(30) : W'(0);
        expect_res(x, 1'b1);
        launch(c); wait_done(n, nb);

        // Ramp round trip (forward model must give 496, -16, -32 ...)
        for (int i = 0; i < N; i++) x[i] = W'(i);
        c = fwd(x);
        check("model_c0", int'($signed(c[0])), 496);
        check("model_c1", int'($signed(c[1])), -16);
        check("model_c2", int'($signed(c[2])), -32);
        expect_res(x, 1'b0);
        launch(c); wait_done(n, nb);

        // Non-divisible, then exact input clears inexact
        c = '0; c[0] = CW'(1);
        expect_res(fill(0), 1'b1);
        launch(c); wait_done(n, nb);
        c = '0; c[0] = CW'(32);
        expect_res(fill(1), 1'b0);
        launch(c); wait_done(n, nb);

        // Start held continuously: done every 7 cycles
        for (int i = 0; i < N; i++) x[i] = W'(31 - i);
        c = fwd(x);
        for (int p = 0; p < 3; p++) expect_res(x, 1'b0);
        @(negedge clk);
        coef  = c;
        start = 1'b1;
        for (int p = 0; p < 3; p++) begin
            n = 0;
            do begin
                @(posedge clk); #1; n = n + 1;
            end while (done !== 1'b1 && n < 40);
            if (done !== 1'b1) check("held_start_timeout", 0, 1);
            t[p] = cyc;
        end
        start = 1'b0;
        check("period_1", t[1] - t[0], 7);
        check("period_2", t[2] - t[1], 7);

        // Start during RUN ignored; coef change during RUN has no effect
        for (int i = 0; i < N; i++) x[i]  = W'((i * 7 + 3) % 32);
        for (int i = 0; i < N; i++) xb[i] = W'((i * 5 + 11) % 32);
        expect_res(x, 1'b0);
        launch(fwd(x));
        @(negedge clk);
        coef  = fwd(xb);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n, nb);
        check("ignored_start_latency", n, 5);
        repeat (10) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);

        // Reset in the third RUN cycle
        launch(fwd(x));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_outdata", int'(outdata == '0), 1);
        check("midrst_busy", int'(busy), 0);
        check("midrst_inexact", int'(inexact), 0);
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone = ndone + 1;
        end
        check("midrst_no_done", ndone, 0);
        expect_res(x, 1'b0);
        launch(fwd(x)); wait_done(n, nb);
        check("after_rst_latency", n, 6);

        // Random round trips
        for (int r = 0; r < 200; r++) begin
            for (int i = 0; i < N; i++) x[i] = W'($urandom_range(0, 31));
            expect_res(x, 1'b0);
            launch(fwd(x));
            wait_done(n, nb);
        end

        repeat (4) @(posedge clk);
        #1;
        check("final_scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish by 1000000 ns, want finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
